// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side arbiter: RAM handshake states,
// arbiter FSM states and the default dcache burst length.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int DEF_BURST_LEN = 2;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating stall counter for a granted RAM transaction. timeout is raised
// in the cycle whose count reaches TIMEOUT, and keeps asserting while the
// counter sits saturated and still counting.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise count up and stick at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = !clear && count && (cnt_d == LIMIT);

    // counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between icache and dcache for the single RAM port.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no RAM enables; picks next owner (round-robin on a tie)
//   IGRANT | icache owns RAM; single-word fetch, abort if iREN drops
//   DGRANT | dcache owns RAM for up to BURST_LEN beats, abort if idle
//
// RAM-side outputs and wait/load returns are combinational from the
// registered state, so an asynchronous reset drops them immediately.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_d_q, last_d_d;
    logic              err_q, err_d;

    ramstate_t ram_st;
    logic      dreq;
    logic      granted;
    logic      ram_access;
    logic      wdog_timeout;

    assign ram_st     = ramstate_t'(ramstate);
    assign dreq       = dREN | dWEN;
    assign granted    = (state_q != IDLE);
    assign ram_access = (ram_st == ACCESS);
    assign err        = err_q;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (!granted || ram_access),
        .count   (granted && !ram_access),
        .timeout (wdog_timeout)
    );

    // next-state, round-robin pointer, beat count and all port muxing
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d_d = last_d_q;
        err_d    = err_q;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                // last_d_q low means the dcache wins the next tie
                if (dreq && (!iREN || !last_d_q)) begin
                    state_d  = DGRANT;
                    last_d_d = 1'b1;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    last_d_d = 1'b0;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = IDLE;
                end
            end

            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (!dreq) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else if (ram_access) begin
                    dwait = 1'b0;
                    dload = dWEN ? '0 : ramload;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        if (granted && (ram_st == ERROR)) err_d = 1'b1;
        if (wdog_timeout)                 err_d = 1'b1;
    end

    // state, beat, round-robin pointer and sticky error registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
        end
    end

endmodule
